mem_fill_responder: RTL and testbench

- Main-memory side of the cache-miss/line-fill interface.
- Accepts level-held miss requests from the I-cache (Fetch) and the D-cache (Memory stage).
- Arbitrates between them round-robin and models a fixed main-memory latency.
- Returns one 128-bit line plus a 9-bit fill tag per request on the WiCache*/WDCache* fill ports.
- Sits at the top level beside Fetch and Memory, closing the loop on ICacheMiss/DCacheMiss.

---
 rtl/mem_fill_responder.sv | 247 ++++++++++++++++++++++++
 tb/tb_mem_fill_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_responder.sv
// -----------------------------------------------------------------------------
// mem_fill_responder
//
// Main-memory side of the cache-miss / line-fill loop. The I-cache (Fetch) and
// the D-cache (Memory stage) each raise a level-held miss with a line index.
// This block picks one of them (round-robin when both are waiting), waits a
// fixed main-memory latency, then returns the line from a small backing store
// together with a zero-extended fill tag on that side's fill port.
//
// Sequence per request:
//   IDLE --(miss sampled at edge k)--> BUSY for MEM_LATENCY edges
//   --> RESP (fill strobe high for one cycle, after edge k+MEM_LATENCY)
//   --> GAP (one quiet cycle so the requester can drop its miss) --> IDLE
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   ICacheMiss, ICacheMiss_tag  I-cache miss level and missing line index
//   DCacheMiss, DCacheMiss_tag  D-cache miss level and missing line index
//   WiCache, WiCacheline,       I-cache fill strobe (one cycle), line, tag
//   WiCachetag
//   WDCache, WDCacheline,       D-cache fill strobe (one cycle), line, tag
//   WDCachetag
//   ld_en, ld_addr, ld_data     backing-store write port (init / test)
//   busy                        high whenever the FSM is not in IDLE
//
// All outputs are registered. Line/tag outputs hold their last fill value
// until the next fill on the same side. The backing store has no reset.
// -----------------------------------------------------------------------------
module mem_fill_responder #(
    parameter int MEM_LATENCY = 10,
    parameter int LINE_W      = 128,
    parameter int TAG_IN_W    = 5,
    parameter int TAG_OUT_W   = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ICacheMiss,
    input  logic [TAG_IN_W-1:0]  ICacheMiss_tag,
    input  logic                 DCacheMiss,
    input  logic [TAG_IN_W-1:0]  DCacheMiss_tag,
    output logic                 WiCache,
    output logic [LINE_W-1:0]    WiCacheline,
    output logic [TAG_OUT_W-1:0] WiCachetag,
    output logic                 WDCache,
    output logic [LINE_W-1:0]    WDCacheline,
    output logic [TAG_OUT_W-1:0] WDCachetag,
    input  logic                 ld_en,
    input  logic [TAG_IN_W-1:0]  ld_addr,
    input  logic [LINE_W-1:0]    ld_data,
    output logic                 busy
);

    localparam int         DEPTH    = 1 << TAG_IN_W;
    // Counter is loaded with LATENCY-1 so that BUSY spans exactly
    // MEM_LATENCY edges, including the edge that leaves BUSY.
    localparam logic [7:0] CNT_INIT = 8'(MEM_LATENCY - 1);
    localparam int         TAG_PAD  = TAG_OUT_W - TAG_IN_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // FSM and request bookkeeping
    state_t               state_r;
    state_t               state_s;
    logic [7:0]           cnt_r;
    logic [7:0]           cnt_s;
    logic                 sel_d_r;     // 1: current request belongs to D-cache
    logic                 sel_d_s;
    logic [TAG_IN_W-1:0]  tag_r;       // latched miss index
    logic [TAG_IN_W-1:0]  tag_s;
    logic                 last_d_r;    // 1: last grant went to D-cache
    logic                 last_d_s;
    logic                 any_miss_s;
    logic                 grant_d_s;
    logic                 fill_i_s;
    logic                 fill_d_s;

    // Backing store and read path
    logic [LINE_W-1:0]    mem_r [DEPTH];
    logic [LINE_W-1:0]    rd_line_s;
    logic [TAG_OUT_W-1:0] fill_tag_s;

    // Registered outputs
    logic                 wi_r;
    logic [LINE_W-1:0]    wi_line_r;
    logic [TAG_OUT_W-1:0] wi_tag_r;
    logic                 wd_r;
    logic [LINE_W-1:0]    wd_line_r;
    logic [TAG_OUT_W-1:0] wd_tag_r;
    logic                 busy_r;

    assign any_miss_s = ICacheMiss | DCacheMiss;

    // The read uses the pre-edge contents, so a same-edge ld_en to the line
    // being returned still delivers the old data.
    assign rd_line_s  = mem_r[tag_r];
    assign fill_tag_s = {{TAG_PAD{1'b0}}, tag_r};

    // Backing-store write port; active in every state and deliberately unreset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_r[ld_addr] <= ld_data;
        end
    end

    // Round-robin arbitration: a lone requester wins, a tie goes to the side
    // that did not win last time.
    always_comb begin
        grant_d_s = 1'b0;
        if (ICacheMiss && DCacheMiss) begin
            grant_d_s = ~last_d_r;
        end else begin
            grant_d_s = DCacheMiss;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic. Misses are only looked at in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_miss_s) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == 8'd0) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_RESP: state_s = ST_GAP;
            ST_GAP:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output logic: request capture, latency countdown and fill decision.
    always_comb begin
        cnt_s    = cnt_r;
        sel_d_s  = sel_d_r;
        tag_s    = tag_r;
        last_d_s = last_d_r;
        fill_i_s = 1'b0;
        fill_d_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_miss_s) begin
                    sel_d_s  = grant_d_s;
                    last_d_s = grant_d_s;
                    cnt_s    = CNT_INIT;
                    if (grant_d_s) begin
                        tag_s = DCacheMiss_tag;
                    end else begin
                        tag_s = ICacheMiss_tag;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_BUSY: begin
                if (cnt_r == 8'd0) begin
                    fill_i_s = ~sel_d_r;
                    fill_d_s = sel_d_r;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ST_RESP: begin
                cnt_s = cnt_r;
            end
            ST_GAP: begin
                cnt_s = cnt_r;
            end
            default: begin
                cnt_s = 8'd0;
            end
        endcase
    end

    // Request bookkeeping registers; reset leaves last grant on the I side so
    // the first tie goes to the D-cache.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= 8'd0;
            sel_d_r  <= 1'b0;
            tag_r    <= {TAG_IN_W{1'b0}};
            last_d_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_s;
            sel_d_r  <= sel_d_s;
            tag_r    <= tag_s;
            last_d_r <= last_d_s;
        end
    end

    // Fill port registers: strobes pulse for the RESP cycle only, line/tag
    // update only on their own side's fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wi_r      <= 1'b0;
            wi_line_r <= {LINE_W{1'b0}};
            wi_tag_r  <= {TAG_OUT_W{1'b0}};
            wd_r      <= 1'b0;
            wd_line_r <= {LINE_W{1'b0}};
            wd_tag_r  <= {TAG_OUT_W{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            wi_r   <= fill_i_s;
            wd_r   <= fill_d_s;
            busy_r <= (state_s != ST_IDLE);
            if (fill_i_s) begin
                wi_line_r <= rd_line_s;
                wi_tag_r  <= fill_tag_s;
            end
            if (fill_d_s) begin
                wd_line_r <= rd_line_s;
                wd_tag_r  <= fill_tag_s;
            end
        end
    end

    assign WiCache     = wi_r;
    assign WiCacheline = wi_line_r;
    assign WiCachetag  = wi_tag_r;
    assign WDCache     = wd_r;
    assign WDCacheline = wd_line_r;
    assign WDCachetag  = wd_tag_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_mem_fill_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_fill_responder
//
// Directed scenarios followed by randomized requester traffic. The reference
// model works in edge numbers: a granted request at edge s fills at s+LAT,
// keeps busy up to s+LAT+1 and allows the next sample at s+LAT+3.
// A second instance built with MEM_LATENCY=1 covers the short-latency case.
// -----------------------------------------------------------------------------
module tb_mem_fill_responder;

    localparam int LAT = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         i_miss, d_miss;
    logic [4:0]   i_tag, d_tag;
    logic         ld_en;
    logic [4:0]   ld_addr;
    logic [127:0] ld_data;
    logic         wi, wd, busy;
    logic [127:0] wi_line, wd_line;
    logic [8:0]   wi_tag, wd_tag;

    // Short-latency instance: shares clock, reset and load port.
    logic         i1_miss, d1_miss;
    logic [4:0]   i1_tag, d1_tag;
    logic         wi1, wd1, busy1;
    logic [127:0] wi1_line, wd1_line;
    logic [8:0]   wi1_tag, wd1_tag;

    mem_fill_responder #(.MEM_LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ICacheMiss(i_miss), .ICacheMiss_tag(i_tag),
        .DCacheMiss(d_miss), .DCacheMiss_tag(d_tag),
        .WiCache(wi), .WiCacheline(wi_line), .WiCachetag(wi_tag),
        .WDCache(wd), .WDCacheline(wd_line), .WDCachetag(wd_tag),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .busy(busy)
    );

    mem_fill_responder #(.MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .ICacheMiss(i1_miss), .ICacheMiss_tag(i1_tag),
        .DCacheMiss(d1_miss), .DCacheMiss_tag(d1_tag),
        .WiCache(wi1), .WiCacheline(wi1_line), .WiCachetag(wi1_tag),
        .WDCache(wd1), .WDCacheline(wd1_line), .WDCachetag(wd1_tag),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .busy(busy1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [127:0] mem_m [32];
    logic         m_pend, m_sel_d, m_last_d;
    logic [4:0]   m_tag;
    int           m_fill_edge, m_next_sample, m_busy_until;
    logic         e_wi, e_wd, e_busy;
    logic [127:0] e_wi_line, e_wd_line;
    logic [8:0]   e_wi_tag, e_wd_tag;

    int edge_no = -1;
    int fe_i, fe_d, base;
    logic gq[$];           // observed grant order, 1 = D
    int i_wait, d_wait;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %h want %h", name, edge_no, got, want);
        end
    endtask

    task automatic model_reset();
        m_pend        = 1'b0;
        m_sel_d       = 1'b0;
        m_last_d      = 1'b0;
        m_tag         = 5'd0;
        m_next_sample = 0;
        m_busy_until  = -1;
        e_wi = 1'b0; e_wd = 1'b0; e_busy = 1'b0;
        e_wi_line = 128'd0; e_wd_line = 128'd0;
        e_wi_tag  = 9'd0;   e_wd_tag  = 9'd0;
    endtask

    // Advance the model by one rising edge given the inputs seen at that edge.
    task automatic model_edge(input logic r, input logic mi, input logic md,
                              input logic [4:0] ti, input logic [4:0] td,
                              input logic le, input logic [4:0] la, input logic [127:0] ldat);
        e_wi = 1'b0;
        e_wd = 1'b0;
        if (!r) begin
            model_reset();
        end else begin
            if (m_pend && edge_no == m_fill_edge) begin
                if (m_sel_d) begin
                    e_wd = 1'b1; e_wd_line = mem_m[m_tag]; e_wd_tag = {4'b0000, m_tag};
                end else begin
                    e_wi = 1'b1; e_wi_line = mem_m[m_tag]; e_wi_tag = {4'b0000, m_tag};
                end
                m_pend = 1'b0;
            end else if (!m_pend && edge_no >= m_next_sample && (mi || md)) begin
                if (mi && md) m_sel_d = ~m_last_d;
                else          m_sel_d = md;
                m_tag         = m_sel_d ? td : ti;
                m_last_d      = m_sel_d;
                m_pend        = 1'b1;
                m_fill_edge   = edge_no + LAT;
                m_busy_until  = edge_no + LAT + 1;
                m_next_sample = edge_no + LAT + 3;
            end
            e_busy = (edge_no <= m_busy_until);
        end
        if (le) mem_m[la] = ldat;
    endtask

    // One clock: capture inputs, cross the edge, update model, compare.
    task automatic step();
        logic r, mi, md, le;
        logic [4:0] ti, td, la;
        logic [127:0] ldat;
        r = rst_n; mi = i_miss; md = d_miss; ti = i_tag; td = d_tag;
        le = ld_en; la = ld_addr; ldat = ld_data;
        @(posedge clk);
        #1;
        edge_no++;
        model_edge(r, mi, md, ti, td, le, la, ldat);
        chk("wi",      128'(wi),      128'(e_wi));
        chk("wd",      128'(wd),      128'(e_wd));
        chk("wi_line", wi_line,       e_wi_line);
        chk("wi_tag",  128'(wi_tag),  128'(e_wi_tag));
        chk("wd_line", wd_line,       e_wd_line);
        chk("wd_tag",  128'(wd_tag),  128'(e_wd_tag));
        chk("busy",    128'(busy),    128'(e_busy));
        chk("excl",    128'(wi & wd), 128'(0));
        if (wi) begin fe_i = edge_no; gq.push_back(1'b0); end
        if (wd) begin fe_d = edge_no; gq.push_back(1'b1); end
    endtask

    task automatic drop_on_fill();
        if (e_wi) i_miss = 1'b0;
        if (e_wd) d_miss = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
    endtask

    // Random requester: hold until fill, then either re-request at once or idle.
    task automatic drive_random();
        if (i_miss) begin
            if (e_wi) begin
                if ($urandom_range(0, 1) == 0) i_tag = 5'($urandom);
                else begin i_miss = 1'b0; i_wait = $urandom_range(0, 6); end
            end else if ($urandom_range(0, 15) == 0) i_tag = 5'($urandom);
        end else if (i_wait == 0) begin
            i_miss = 1'b1; i_tag = 5'($urandom);
        end else i_wait--;
        if (d_miss) begin
            if (e_wd) begin
                if ($urandom_range(0, 1) == 0) d_tag = 5'($urandom);
                else begin d_miss = 1'b0; d_wait = $urandom_range(0, 6); end
            end else if ($urandom_range(0, 15) == 0) d_tag = 5'($urandom);
        end else if (d_wait == 0) begin
            d_miss = 1'b1; d_tag = 5'($urandom);
        end else d_wait--;
        ld_en   = ($urandom_range(0, 7) == 0);
        ld_addr = (m_pend && $urandom_range(0, 1) == 0) ? m_tag : 5'($urandom);
        ld_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        logic [127:0] old7, new7;
        rst_n = 1'b0;
        i_miss = 1'b0; d_miss = 1'b0; i_tag = 5'd0; d_tag = 5'd0;
        i1_miss = 1'b0; d1_miss = 1'b0; i1_tag = 5'd0; d1_tag = 5'd0;
        ld_en = 1'b0; ld_addr = 5'd0; ld_data = 128'd0;
        fe_i = -100; fe_d = -100;
        model_reset();

        // Preload the store while reset holds all outputs at 0.
        for (int a = 0; a < 32; a++) begin
            ld_en = 1'b1; ld_addr = 5'(a);
            ld_data = {{3{32'hA5A5_A5A5}}, 32'(a)};
            step();
        end
        ld_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Single I miss: latency and data.
        i_miss = 1'b1; i_tag = 5'd3; base = edge_no + 1;
        for (int k = 0; k < 14; k++) begin step(); drop_on_fill(); end
        chk("t1_lat",  128'(fe_i - base), 128'(LAT));
        chk("t1_line", wi_line, {{3{32'hA5A5_A5A5}}, 32'd3});
        chk("t1_tag",  128'(wi_tag), 128'(9'h003));

        // Both misses after reset: D first, then I at the next sample slot.
        do_reset();
        i_miss = 1'b1; i_tag = 5'd1; d_miss = 1'b1; d_tag = 5'd2; base = edge_no + 1;
        for (int k = 0; k < 26; k++) begin step(); drop_on_fill(); end
        chk("t2_d_lat", 128'(fe_d - base), 128'(LAT));
        chk("t2_i_lat", 128'(fe_i - base), 128'(2 * LAT + 3));
        chk("t2_d_tag", 128'(wd_tag), 128'(9'h002));
        chk("t2_i_tag", 128'(wi_tag), 128'(9'h001));

        // Both held continuously: alternation D, I, D, I.
        do_reset();
        gq.delete();
        i_miss = 1'b1; i_tag = 5'd4; d_miss = 1'b1; d_tag = 5'd5;
        for (int k = 0; k < 4 * (LAT + 3); k++) step();
        i_miss = 1'b0; d_miss = 1'b0;
        chk("t3_count", 128'(gq.size()), 128'(4));
        for (int g = 0; g < gq.size(); g++) chk("t3_order", 128'(gq[g]), 128'((g % 2) == 0));
        step();

        // Reset during a pending fill.
        d_miss = 1'b1; d_tag = 5'd5;
        for (int k = 0; k < 5; k++) step();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_wd",    128'(wd),      128'(0));
        chk("t5_wline", wd_line,       128'(0));
        chk("t5_wtag",  128'(wd_tag),  128'(0));
        chk("t5_iline", wi_line,       128'(0));
        chk("t5_busy",  128'(busy),    128'(0));
        step();
        rst_n = 1'b1;
        base = edge_no + 1;
        for (int k = 0; k < 14; k++) begin step(); drop_on_fill(); end
        chk("t5_lat", 128'(fe_d - base), 128'(LAT));

        // Load-port collision on the fill edge returns old data.
        old7 = mem_m[7];
        new7 = {$urandom, $urandom, $urandom, $urandom};
        d_miss = 1'b1; d_tag = 5'd7;
        for (int k = 0; k < LAT; k++) step();
        ld_en = 1'b1; ld_addr = 5'd7; ld_data = new7;
        step();
        ld_en = 1'b0; d_miss = 1'b0;
        chk("t6_strobe", 128'(wd), 128'(1));
        chk("t6_old", wd_line, old7);
        for (int k = 0; k < 3; k++) step();
        d_miss = 1'b1;
        for (int k = 0; k < 14; k++) begin step(); drop_on_fill(); end
        chk("t6_new", wd_line, new7);

        // MEM_LATENCY=1 instance, D miss held through two fills.
        d1_miss = 1'b1; d1_tag = 5'd9;
        step(); chk("t4_busy_e0", 128'(busy1), 128'(1)); chk("t4_wd_e0", 128'(wd1), 128'(0));
        step(); chk("t4_wd_e1", 128'(wd1), 128'(1));
        chk("t4_line", wd1_line, mem_m[9]); chk("t4_tag", 128'(wd1_tag), 128'(9'h009));
        step(); chk("t4_wd_e2", 128'(wd1), 128'(0)); chk("t4_busy_e2", 128'(busy1), 128'(1));
        step(); chk("t4_busy_e3", 128'(busy1), 128'(0));
        step(); chk("t4_busy_e4", 128'(busy1), 128'(1));
        step(); chk("t4_wd_e5", 128'(wd1), 128'(1));
        d1_miss = 1'b0;
        step(); chk("t4_wd_e6", 128'(wd1), 128'(0));
        chk("t4_wi",     128'(wi1),     128'(0));
        chk("t4_wiline", wi1_line,      128'(0));
        chk("t4_witag",  128'(wi1_tag), 128'(0));

        // Randomized traffic against the model.
        i_wait = $urandom_range(0, 4); d_wait = $urandom_range(0, 4);
        for (int k = 0; k < 3000; k++) begin
            step();
            drive_random();
        end
        i_miss = 1'b0; d_miss = 1'b0; ld_en = 1'b0;
        for (int k = 0; k < LAT + 4; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
